// File: rtl/risc_v_32_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
//   - funct3 operation encodings (OP_MUL .. OP_REMU)
//   - FSM state encoding (S_IDLE, S_CALC, S_FIX, S_DONE)
//   - INT_MIN / ALL_ONES constants used by the divide special cases
//   - small decode helpers for operand signedness and op class
package risc_v_32_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Divide class: DIV, DIVU, REM, REMU.
    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // Remainder class: REM, REMU.
    function automatic logic op_is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM (MULHSU treats rs2 unsigned).
    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/risc_v_32_muldiv_step.sv
// One combinational iteration shared by the multiply and divide datapaths.
// The 64-bit accumulator is {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits.
//             Add the multiplicand into hi when lo[0] is set, then shift the
//             whole 65-bit {carry, hi, lo} right by one.
//   divide:   hi = partial remainder, lo = dividend bits / quotient bits.
//             Shift left by one, trial-subtract the divisor from the upper
//             bits, keep the difference and shift in a 1 when no borrow.
// Ports:
//   acc      in  accumulator before this iteration
//   operand  in  multiplicand (mul) or divisor (div), unsigned magnitude
//   is_div   in  selects the divide iteration
//   acc_next out accumulator after this iteration
module risc_v_32_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_diff;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]};
        if (acc[0]) begin
            mul_sum = mul_sum + {1'b0, operand};
        end
        // acc[2*XLEN-1:XLEN-1] is the upper half after the left shift,
        // one bit wider so the shifted-out remainder bit is not lost.
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
        if (is_div) begin
            if (div_diff[XLEN]) begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end else begin
                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/risc_v_32_muldiv.sv
// Iterative RV32M multiply/divide unit placed after the register file read
// ports. Operands are converted to magnitudes at start, 32 shift-add or
// restoring-divide iterations run in CALC, and the sign is fixed in FIX.
//
// Handshake: start is sampled only while busy is low. Once accepted, busy
// stays high through CALC, FIX and DONE; further starts are ignored and the
// operands are not re-sampled. done pulses for exactly one cycle with result,
// rd_out and wreg valid; the caller may present the next start in the
// following cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   clrn    in   asynchronous active-low reset
//   start   in   operation request
//   funct3  in   RV32M operation
//   a, b    in   rs1 / rs2 operands
//   rd_in   in   destination register
//   busy    out  high whenever the FSM is not idle
//   done    out  one-cycle result-valid pulse
//   result  out  result, held until overwritten by the next operation
//   rd_out  out  destination captured at start
//   wreg    out  register file write enable (done and rd_out != 0)
module risc_v_32_muldiv
    import risc_v_32_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wreg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic              neg;
    logic              special;

    // Start-time decode
    logic            in_div;
    logic            in_rem;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_val;

    always_comb begin
        in_div      = op_is_div(funct3);
        in_rem      = op_is_rem(funct3);
        sa          = op_a_signed(funct3) & a[XLEN-1];
        sb          = op_b_signed(funct3) & b[XLEN-1];
        abs_a       = sa ? (~a + 1'b1) : a;
        abs_b       = sb ? (~b + 1'b1) : b;
        div_zero    = in_div && (b == '0);
        // Only the signed ops (funct3[0]==0) can overflow.
        div_ovf     = in_div && !funct3[0] && (a == INT_MIN) && (b == ALL_ONES);
        if (div_zero) begin
            special_val = in_rem ? a : ALL_ONES;
        end else begin
            special_val = in_rem ? '0 : INT_MIN;
        end
    end

    risc_v_32_muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op[2]),
        .acc_next (acc_next)
    );

    // Sign fix-up: product negation covers all 64 bits so MULH* see the
    // correct borrow into the upper half.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod_fix = neg ? (~acc + 1'b1) : acc;
        quo_fix  = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        if (special) begin
            fix_val = acc[XLEN-1:0];
        end else if (!op[2]) begin
            fix_val = (op == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (op[1]) begin
            fix_val = rem_fix;
        end else begin
            fix_val = quo_fix;
        end
    end

    // Special divide cases skip CALC and pass through FIX with the fix-up
    // bypassed, so every result reaches the output through the same register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op      <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg     <= 1'b0;
            special <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        rd_out <= rd_in;
                        cnt    <= '0;
                        if (div_zero || div_ovf) begin
                            special <= 1'b1;
                            neg     <= 1'b0;
                            acc     <= {{XLEN{1'b0}}, special_val};
                            state   <= S_FIX;
                        end else begin
                            special <= 1'b0;
                            neg     <= in_rem ? sa : (sa ^ sb);
                            // mul: lo = multiplier |b|, operand = |a|
                            // div: lo = dividend |a|, operand = divisor |b|
                            acc     <= {{XLEN{1'b0}}, in_div ? abs_a : abs_b};
                            opnd    <= in_div ? abs_b : abs_a;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= fix_val;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign wreg = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_risc_v_32_muldiv.sv
// Scoreboard bench for risc_v_32_muldiv: the driver pushes the hand-computed
// result, destination, write enable and expected done cycle for every
// accepted operation; a monitor pops and compares on each done pulse.
module tb_risc_v_32_muldiv;
    import risc_v_32_muldiv_pkg::*;

    localparam int W = 54;  // {done_cycle[15:0], wreg, rd[4:0], result[31:0]}

    logic        clk;
    logic        clrn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wreg;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;
    int cyc;

    risc_v_32_muldiv dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .wreg   (wreg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (clrn && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e[31:0]);
                check("rd_out", 32'(rd_out), 32'(e[36:32]));
                check("wreg", 32'(wreg), 32'(e[37]));
                check("done_cycle", 32'(cyc[15:0]), 32'(e[53:38]));
            end
        end
    end

    // Driver: called at a negedge, returns at the negedge after done.
    task automatic do_op(input logic [2:0] f, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [4:0] rd, input logic [31:0] exp_res,
                         input bit spec, input bit glitch);
        int c0;
        int n;
        bit busy_ok;
        funct3 = f;
        a      = op_a;
        b      = op_b;
        rd_in  = rd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        exp_q.push_back({16'(c0 + (spec ? 1 : 33)), (rd != 5'd0), rd, exp_res});
        @(negedge clk);
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        funct3  = 3'($urandom_range(0, 7));
        rd_in   = 5'($urandom_range(0, 31));
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (glitch && n == 4) begin
                start  = 1'b1;
                funct3 = OP_MUL;
                a      = 32'd5;
                b      = 32'd5;
                rd_in  = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (!busy) busy_ok = 1'b0;
        check("busy_during_op", 32'(busy_ok), 32'd1);
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks   = 0;
        failures = 0;
        clrn     = 1'b0;
        start    = 1'b0;
        funct3   = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        rd_in    = 5'd0;
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_wreg", 32'(wreg), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        // Multiply
        do_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 1'b0);
        do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0, 1'b0);
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(OP_MULHU,  32'h0001_0000, 32'h0001_0000, 5'd9,  32'h0000_0001, 1'b0, 1'b0);
        do_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1'b0, 1'b0);
        do_op(OP_MULH,   32'd2,         32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(OP_MUL,    32'd3,         32'd4,         5'd0,  32'd12,        1'b0, 1'b0);

        // Divide
        do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(OP_DIVU,   32'd100,       32'd7,         5'd14, 32'd14,        1'b0, 1'b0);
        do_op(OP_REMU,   32'd100,       32'd7,         5'd15, 32'd2,         1'b0, 1'b0);
        do_op(OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op(OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd17, 32'd1,         1'b0, 1'b0);
        do_op(OP_DIV,    32'h8000_0000, 32'd2,         5'd18, 32'hC000_0000, 1'b0, 1'b0);
        do_op(OP_DIVU,   32'd5,         32'd9,         5'd19, 32'd0,         1'b0, 1'b0);
        do_op(OP_REMU,   32'd5,         32'd9,         5'd20, 32'd5,         1'b0, 1'b0);
        do_op(OP_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd21, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Special cases
        do_op(OP_DIV,    32'd42,        32'd0,         5'd22, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(OP_REM,    32'd42,        32'd0,         5'd23, 32'd42,        1'b1, 1'b0);
        do_op(OP_DIVU,   32'd42,        32'd0,         5'd24, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(OP_REMU,   32'd42,        32'd0,         5'd25, 32'd42,        1'b1, 1'b0);
        do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 32'h8000_0000, 1'b1, 1'b0);
        do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 32'd0,         1'b1, 1'b0);

        // Start pulsed mid-operation must be ignored
        do_op(OP_DIVU,   32'd100,       32'd7,         5'd28, 32'd14,        1'b0, 1'b1);

        // Asynchronous reset in the middle of a DIVU: no result must appear
        funct3 = OP_DIVU;
        a      = 32'd1000;
        b      = 32'd3;
        rd_in  = 5'd9;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wreg", 32'(wreg), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_rd_out", 32'(rd_out), 32'd0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        do_op(OP_MUL,    32'd3,         32'd4,         5'd7,  32'd12,        1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
